// File: rtl/axi_lite_stream_slave.sv
// AXI-lite slave that re-emits each accepted write as an {addr,data} stream beat
// and each accepted read as an address-only beat, then returns the read data
// arriving on the response stream. One transaction is in flight at a time.
`timescale 1ns/1ps
module axi_lite_stream_slave #(
    parameter int DATA_WD           = 8,
    parameter int ADDR_WD           = 8,
    parameter int DATA_ADDR_BYTE_WD = (DATA_WD + ADDR_WD) >> 3,
    parameter int RSP_TIMEOUT       = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         awvalid,
    input  logic [ADDR_WD-1:0]           awaddr,
    output logic                         awready,
    input  logic                         wvalid,
    input  logic [DATA_WD-1:0]           wdata,
    output logic                         wready,
    output logic                         bvalid,
    output logic [1:0]                   brsp,
    input  logic                         bready,
    input  logic                         arvalid,
    input  logic [ADDR_WD-1:0]           araddr,
    output logic                         arready,
    output logic                         rvalid,
    output logic [DATA_WD-1:0]           rdata,
    output logic [1:0]                   rrsp,
    input  logic                         rready,
    output logic                         tvalid,
    output logic [ADDR_WD+DATA_WD-1:0]   tdata,
    output logic [DATA_ADDR_BYTE_WD-1:0] tkeep,
    input  logic                         tready,
    input  logic                         rsp_tvalid,
    input  logic [DATA_WD-1:0]           rsp_tdata,
    output logic                         rsp_tready
);

    localparam int ADDR_BYTES = ADDR_WD / 8;
    localparam int DATA_BYTES = DATA_WD / 8;
    // One extra count of headroom so RSP_TIMEOUT itself is representable.
    localparam int CNT_W      = $clog2(RSP_TIMEOUT + 2);

    typedef enum logic [2:0] {
        IDLE, WR_ACC, WR_PUSH, WR_RESP, RD_ACC, RD_PUSH, RD_WAIT, RD_RESP
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_WD-1:0] addr_q;
    logic [DATA_WD-1:0] data_q;
    logic               aw_got, w_got;
    logic               last_rd;
    logic [CNT_W-1:0]   cnt;
    logic               timeout_hit;

    // A zero RSP_TIMEOUT means wait forever for the read return.
    assign timeout_hit = (RSP_TIMEOUT != 0) && (cnt == CNT_W'(RSP_TIMEOUT));
    assign brsp        = 2'b00;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and handshake outputs, all driven from registered state only.
    always_comb begin
        state_nxt  = state;
        awready    = 1'b0;
        wready     = 1'b0;
        arready    = 1'b0;
        tvalid     = 1'b0;
        tdata      = '0;
        tkeep      = '0;
        bvalid     = 1'b0;
        rvalid     = 1'b0;
        rsp_tready = 1'b0;
        case (state)
            IDLE: begin
                if ((awvalid || wvalid) && (!arvalid || last_rd)) state_nxt = WR_ACC;
                else if (arvalid)                                   state_nxt = RD_ACC;
            end
            WR_ACC: begin
                awready = !aw_got;
                wready  = !w_got;
                if ((aw_got || awvalid) && (w_got || wvalid)) state_nxt = WR_PUSH;
            end
            WR_PUSH: begin
                tvalid = 1'b1;
                tdata  = {addr_q, data_q};
                tkeep  = '1;
                if (tready) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) state_nxt = IDLE;
            end
            RD_ACC: begin
                arready = 1'b1;
                if (arvalid) state_nxt = RD_PUSH;
            end
            RD_PUSH: begin
                tvalid = 1'b1;
                tdata  = {addr_q, {DATA_WD{1'b0}}};
                tkeep  = {{ADDR_BYTES{1'b1}}, {DATA_BYTES{1'b0}}};
                if (tready) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                rsp_tready = 1'b1;
                if (rsp_tvalid || timeout_hit) state_nxt = RD_RESP;
            end
            RD_RESP: begin
                rvalid = 1'b1;
                if (rready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payload capture, arbitration memory, timeout counter and read response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            data_q  <= '0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            last_rd <= 1'b1;
            cnt     <= '0;
            rdata   <= '0;
            rrsp    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    aw_got <= 1'b0;
                    w_got  <= 1'b0;
                    if (state_nxt == WR_ACC)      last_rd <= 1'b0;
                    else if (state_nxt == RD_ACC) last_rd <= 1'b1;
                end
                WR_ACC: begin
                    if (awvalid && !aw_got) begin
                        addr_q <= awaddr;
                        aw_got <= 1'b1;
                    end
                    if (wvalid && !w_got) begin
                        data_q <= wdata;
                        w_got  <= 1'b1;
                    end
                end
                RD_ACC: begin
                    cnt <= '0;
                    if (arvalid) addr_q <= araddr;
                end
                RD_WAIT: begin
                    // A return arriving on the timeout cycle still wins.
                    if (rsp_tvalid) begin
                        rdata <= rsp_tdata;
                        rrsp  <= 2'b00;
                    end else if (timeout_hit) begin
                        rdata <= '0;
                        rrsp  <= 2'b10;
                    end else if (RSP_TIMEOUT != 0) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
